// File: rtl/tm1640_ctrl.sv
// TM1640 frame sequencer: turns a 16-byte segment image plus brightness and
// on/off settings into the 19-byte, three-frame refresh transaction. Bytes are
// fed to the downstream serialiser over its latch/busy handshake, and in-frame
// bytes use its continuation rule.
module tm1640_ctrl #(
   parameter int GAP_CYCLES     = 16,
   parameter int REFRESH_CYCLES = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] segs,
   input  logic [2:0]   brightness,
   input  logic         display_on,
   output logic         ready,
   output logic         done,
   output logic         data_latch,
   output logic [7:0]   data_in,
   output logic         data_stop_bit,
   input  logic         busy
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [4:0] LAST_IDX = 5'd18;
   localparam logic [4:0] LAST_GRID_IDX = 5'd17;

   typedef enum logic [2:0] {
      IDLE,
      FIRE,
      ARM,
      STREAM,
      GAP,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           pending;
   logic           refresh_tick;
   logic [GW-1:0]  gap_cnt;
   logic [4:0]     staged_idx;
   logic [4:0]     inflight_idx;
   logic           inflight_stop;
   logic [127:0]   shadow_segs;
   logic [2:0]     shadow_bright;
   logic           shadow_on;

   logic           accept;
   logic           capture;
   logic           stage_en;
   logic [4:0]     stage_sel;
   logic [7:0]     stage_byte;
   logic           stage_stop;
   logic [3:0]     grid_idx;

   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         logic [RW-1:0] refresh_cnt;

         // Free-running period counter; wraps and ticks on its last count.
         always_ff @(posedge clk) begin
            if (rst) begin
               refresh_cnt <= '0;
            end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
               refresh_cnt <= '0;
            end else begin
               refresh_cnt <= refresh_cnt + RW'(1);
            end
         end

         assign refresh_tick = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
      end else begin : g_no_refresh
         assign refresh_tick = 1'b0;
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, handshake outputs and the staging/capture strobes for the datapath.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      stage_en   = 1'b0;
      stage_sel  = staged_idx + 5'd1;
      ready      = 1'b0;
      done       = 1'b0;
      data_latch = 1'b0;
      case (state)
         IDLE: begin
            ready = ~pending;
            if (start || pending || refresh_tick) begin
               accept     = 1'b1;
               stage_en   = 1'b1;
               stage_sel  = 5'd0;
               state_next = FIRE;
            end
         end
         FIRE: begin
            data_latch = 1'b1;
            capture    = 1'b1;
            stage_en   = ~data_stop_bit;
            state_next = ARM;
         end
         ARM: begin
            state_next = STREAM;
         end
         STREAM: begin
            if (!busy) begin
               if (!inflight_stop) begin
                  capture    = 1'b1;
                  stage_en   = 1'b1;
                  state_next = ARM;
               end else if (inflight_idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  stage_en   = 1'b1;
                  stage_sel  = inflight_idx + 5'd1;
                  state_next = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
               state_next = FIRE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Byte table: command bytes, the 16 grid bytes from the snapshot, then display control.
   always_comb begin
      stage_byte = 8'h00;
      stage_stop = 1'b0;
      grid_idx   = 4'(stage_sel - 5'd2);
      if (stage_sel == 5'd0) begin
         stage_byte = 8'h40;
         stage_stop = 1'b1;
      end else if (stage_sel == 5'd1) begin
         stage_byte = 8'hC0;
         stage_stop = 1'b0;
      end else if (stage_sel <= LAST_GRID_IDX) begin
         stage_byte = shadow_segs[{grid_idx, 3'b000} +: 8];
         stage_stop = (stage_sel == LAST_GRID_IDX);
      end else begin
         stage_byte = shadow_on ? {5'b10001, shadow_bright} : 8'h80;
         stage_stop = 1'b1;
      end
   end

   // Snapshot, staged byte, in-flight tracking and the one-deep pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_segs   <= '0;
         shadow_bright <= '0;
         shadow_on     <= 1'b0;
         staged_idx    <= '0;
         data_in       <= 8'h00;
         data_stop_bit <= 1'b0;
         inflight_idx  <= '0;
         inflight_stop <= 1'b0;
         pending       <= 1'b0;
      end else begin
         if (accept) begin
            shadow_segs   <= segs;
            shadow_bright <= brightness;
            shadow_on     <= display_on;
         end
         if (capture) begin
            inflight_idx  <= staged_idx;
            inflight_stop <= data_stop_bit;
         end
         if (stage_en) begin
            staged_idx    <= stage_sel;
            data_in       <= stage_byte;
            data_stop_bit <= stage_stop;
         end
         if (accept) begin
            pending <= 1'b0;
         end else if (state != IDLE && (start || refresh_tick)) begin
            pending <= 1'b1;
         end
      end
   end

   // Idle spacing between frames.
   always_ff @(posedge clk) begin
      if (rst || state != GAP) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

endmodule

// File: tb/tb_tm1640_ctrl.sv
// Bench for tm1640_ctrl: two instances, one on-demand and one auto-refreshing,
// each driving a behavioural TM1640 serialiser that logs every byte it takes.
module tb_tm1640_ctrl;

   localparam int BYTE_CYCLES = 8;
   localparam int REFRESH_B   = 2000;

   logic         clk = 1'b0;
   logic         rst, start, displayOn;
   logic [127:0] segs;
   logic [2:0]   brightness;
   logic         ready, done, dataLatch, dataStopBit, busy;
   logic [7:0]   dataIn;

   logic         rstB, startB, displayOnB;
   logic [127:0] segsB;
   logic [2:0]   brightnessB;
   logic         readyB, doneB, dataLatchB, dataStopBitB, busyB;
   logic [7:0]   dataInB;

   logic [8:0]   logA[$];
   logic [8:0]   logB[$];
   logic [8:0]   expQ[$];
   int           startsB[$];
   int           cntA = 0, cntB = 0, cycB = 0;
   logic         dipA = 1'b0, dipB = 1'b0, curStopA = 1'b0, curStopB = 1'b0;
   int           latchCntA = 0, latchCntB = 0, doneCntA = 0, violA = 0, violB = 0;
   int           checks = 0, errors = 0;

   tm1640_ctrl #(.GAP_CYCLES(4), .REFRESH_CYCLES(0)) dutA (
      .clk(clk), .rst(rst), .start(start), .segs(segs), .brightness(brightness),
      .display_on(displayOn), .ready(ready), .done(done), .data_latch(dataLatch),
      .data_in(dataIn), .data_stop_bit(dataStopBit), .busy(busy)
   );

   tm1640_ctrl #(.GAP_CYCLES(16), .REFRESH_CYCLES(REFRESH_B)) dutB (
      .clk(clk), .rst(rstB), .start(startB), .segs(segsB), .brightness(brightnessB),
      .display_on(displayOnB), .ready(readyB), .done(doneB), .data_latch(dataLatchB),
      .data_in(dataInB), .data_stop_bit(dataStopBitB), .busy(busyB)
   );

   always #5 clk = ~clk;

   // Serialiser model A: a stop=0 byte ends with a one-cycle busy dip in which the staged byte is taken.
   always @(posedge clk) begin
      if (dataLatch && busy) violA <= violA + 1;
      if (dataLatch) latchCntA <= latchCntA + 1;
      if (done) doneCntA <= doneCntA + 1;
      if (rst) begin
         busy <= 1'b0; dipA <= 1'b0; cntA <= 0; curStopA <= 1'b0;
      end else if (dipA) begin
         busy <= 1'b1; dipA <= 1'b0; cntA <= BYTE_CYCLES - 1;
      end else if (busy) begin
         if (cntA == 0) begin
            busy <= 1'b0;
            if (!curStopA) begin
               dipA <= 1'b1;
               logA.push_back({dataStopBit, dataIn});
               curStopA <= dataStopBit;
            end
         end else begin
            cntA <= cntA - 1;
         end
      end else if (dataLatch) begin
         busy <= 1'b1; cntA <= BYTE_CYCLES - 1;
         logA.push_back({dataStopBit, dataIn});
         curStopA <= dataStopBit;
      end
   end

   // Serialiser model B, plus the cycle stamp of every transaction's first latch.
   always @(posedge clk) begin
      cycB <= cycB + 1;
      if (dataLatchB && busyB) violB <= violB + 1;
      if (dataLatchB) latchCntB <= latchCntB + 1;
      if (dataLatchB && dataInB == 8'h40) startsB.push_back(cycB);
      if (rstB) begin
         busyB <= 1'b0; dipB <= 1'b0; cntB <= 0; curStopB <= 1'b0;
      end else if (dipB) begin
         busyB <= 1'b1; dipB <= 1'b0; cntB <= BYTE_CYCLES - 1;
      end else if (busyB) begin
         if (cntB == 0) begin
            busyB <= 1'b0;
            if (!curStopB) begin
               dipB <= 1'b1;
               logB.push_back({dataStopBitB, dataInB});
               curStopB <= dataStopBitB;
            end
         end else begin
            cntB <= cntB - 1;
         end
      end else if (dataLatchB) begin
         busyB <= 1'b1; cntB <= BYTE_CYCLES - 1;
         logB.push_back({dataStopBitB, dataInB});
         curStopB <= dataStopBitB;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] img, input logic [2:0] br, input logic on);
      segs = img;
      brightness = br;
      displayOn = on;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [127:0] randImg();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference transaction: {stop, byte} for all 19 bytes, built straight from the byte rules.
   task automatic buildExpected(input logic [127:0] img, input logic [2:0] br, input logic on);
      expQ.delete();
      expQ.push_back({1'b1, 8'h40});
      expQ.push_back({1'b0, 8'hC0});
      for (int g = 0; g < 16; g++) expQ.push_back({g == 15, img[8*g +: 8]});
      expQ.push_back({1'b1, on ? (8'h88 | {5'b00000, br}) : 8'h80});
   endtask

   task automatic checkTransaction(input string tag, input bit useB, input int base,
                                   input logic [127:0] img, input logic [2:0] br, input logic on);
      logic [8:0] obs;
      int         sz;
      buildExpected(img, br, on);
      sz = useB ? logB.size() : logA.size();
      checkOutput({tag, "_len"}, 32'(sz >= base + 19), 32'd1);
      for (int i = 0; i < 19; i++) begin
         obs = 'x;
         if (base + i < sz) obs = useB ? logB[base + i] : logA[base + i];
         checkOutput($sformatf("%s_b%0d", tag, i), 32'(obs), 32'(expQ[i]));
      end
   endtask

   task automatic waitDone(input int target, input int budget, input string tag);
      int k = 0;
      while (doneCntA < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, doneCntA, target);
   endtask

   task automatic waitLog(input int n, input int budget, input string tag);
      int k = 0;
      while (logA.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 32'(logA.size() >= n), 32'd1);
   endtask

   initial begin
      logic [127:0] img1, img2, imgA, imgB, imgC, imgE, imgF;
      int d0, l0, k;

      rst = 1'b1; rstB = 1'b1; start = 1'b0; startB = 1'b0;
      segs = '0; brightness = '0; displayOn = 1'b0;
      segsB = randImg(); brightnessB = 3'd3; displayOnB = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0; rstB = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_latch", 32'(dataLatch), 32'd0);
      checkOutput("rst_data", 32'(dataIn), 32'h00);
      checkOutput("rst_stop", 32'(dataStopBit), 32'd0);

      $display("[TB] basic transaction");
      img1 = 128'h0F0E0D0C0B0A09080706050403020100;
      logA.delete(); l0 = latchCntA; d0 = doneCntA;
      applyStimulus(img1, 3'd5, 1'b1);
      checkOutput("t1_latch_n1", 32'(dataLatch), 32'd1);
      checkOutput("t1_first_byte", 32'(dataIn), 32'h40);
      checkOutput("t1_first_stop", 32'(dataStopBit), 32'd1);
      checkOutput("t1_ready_busy", 32'(ready), 32'd0);
      waitDone(d0 + 1, 3000, "t1_done");
      checkOutput("t1_ready_back", 32'(ready), 32'd1);
      checkTransaction("t1", 1'b0, 0, img1, 3'd5, 1'b1);
      checkOutput("t1_latches", latchCntA - l0, 3);

      $display("[TB] display off, start coincident with done");
      img2 = randImg();
      logA.delete(); l0 = latchCntA; d0 = doneCntA;
      applyStimulus(img2, 3'd7, 1'b0);
      k = 0;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checkOutput("t2_done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("t2_pending_ready", 32'(ready), 32'd0);
      @(negedge clk);
      checkOutput("t2_relatch", 32'(dataLatch), 32'd1);
      checkOutput("t2_relatch_byte", 32'(dataIn), 32'h40);
      waitDone(d0 + 2, 3000, "t2_done2");
      checkTransaction("t2a", 1'b0, 0, img2, 3'd7, 1'b0);
      checkTransaction("t2b", 1'b0, 19, img2, 3'd7, 1'b0);

      $display("[TB] merged starts during a transaction");
      imgA = randImg(); imgB = randImg();
      logA.delete(); l0 = latchCntA; d0 = doneCntA;
      applyStimulus(imgA, 3'd2, 1'b1);
      waitLog(8, 2000, "t3_wait8");
      applyStimulus(imgB, 3'd6, 1'b1);
      checkOutput("t3_ready_pending", 32'(ready), 32'd0);
      waitLog(14, 2000, "t3_wait14");
      applyStimulus(imgB, 3'd6, 1'b1);
      waitLog(19, 2000, "t3_wait19");
      applyStimulus(imgB, 3'd6, 1'b1);
      waitDone(d0 + 2, 3000, "t3_done2");
      repeat (300) @(negedge clk);
      checkOutput("t3_no_third", doneCntA, d0 + 2);
      checkOutput("t3_latches", latchCntA - l0, 6);
      checkOutput("t3_bytes", logA.size(), 38);
      checkOutput("t3_ready", 32'(ready), 32'd1);
      checkTransaction("t3a", 1'b0, 0, imgA, 3'd2, 1'b1);
      checkTransaction("t3b", 1'b0, 19, imgB, 3'd6, 1'b1);

      $display("[TB] inputs change after accept");
      imgC = randImg();
      logA.delete(); d0 = doneCntA;
      applyStimulus(imgC, 3'd1, 1'b1);
      segs = randImg(); brightness = 3'd4; displayOn = 1'b0;
      waitDone(d0 + 1, 3000, "t4_done");
      checkTransaction("t4", 1'b0, 0, imgC, 3'd1, 1'b1);

      $display("[TB] reset mid-transaction");
      imgE = randImg();
      logA.delete(); d0 = doneCntA;
      applyStimulus(imgE, 3'd3, 1'b1);
      waitLog(10, 2000, "t5_wait10");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t5_ready", 32'(ready), 32'd1);
      checkOutput("t5_done", 32'(done), 32'd0);
      checkOutput("t5_latch", 32'(dataLatch), 32'd0);
      checkOutput("t5_data", 32'(dataIn), 32'h00);
      checkOutput("t5_stop", 32'(dataStopBit), 32'd0);
      repeat (300) @(negedge clk);
      checkOutput("t5_no_done", doneCntA, d0);
      checkOutput("t5_no_more_bytes", logA.size(), 10);
      imgF = randImg();
      logA.delete(); d0 = doneCntA;
      applyStimulus(imgF, 3'd0, 1'b1);
      waitDone(d0 + 1, 3000, "t5_done_after");
      checkTransaction("t5", 1'b0, 0, imgF, 3'd0, 1'b1);

      $display("[TB] auto-refresh instance");
      while (cycB < 3 * REFRESH_B + 600) @(negedge clk);
      checkOutput("r_count", 32'(startsB.size() >= 3), 32'd1);
      for (int i = 1; i < 3; i++) begin
         checkOutput($sformatf("r_spacing%0d", i),
                     (i < startsB.size()) ? startsB[i] - startsB[i-1] : -1, REFRESH_B);
      end
      checkOutput("r_latches", latchCntB, 3 * startsB.size());
      checkOutput("r_ready", 32'(readyB), 32'd1);
      checkOutput("r_done_idle", 32'(doneB), 32'd0);
      checkTransaction("r0", 1'b1, 0, segsB, 3'd3, 1'b1);
      checkTransaction("r2", 1'b1, 38, segsB, 3'd3, 1'b1);
      checkOutput("viol_a", violA, 0);
      checkOutput("viol_b", violB, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tm1640_ctrl.md
# tm1640_ctrl

Frame sequencer directly upstream of the TM1640 byte-serialiser on the 7-segment PMOD. It takes a 16-byte segment image plus brightness and on/off settings, and emits the complete TM1640 refresh transaction as 19 bytes in three start/stop frames. Bytes are delivered over the serialiser's latch/busy handshake, including the in-frame continuation rule. The block supports on-demand updates and optional periodic auto-refresh.

## Interface
- GAP_CYCLES, 16: idle clk cycles between end of one frame (serialiser busy low) and next data_latch; minimum 1.
- REFRESH_CYCLES, 0: auto-refresh period in clk cycles; 0 disables auto-refresh.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high (shared with serialiser).
- start  in  1  single-cycle update request.
- segs  in  128  segment image; grid n byte = segs[8n+7:8n], n=0..15.
- brightness  in  3  pulse-width setting 0..7.
- display_on  in  1  1 = display enabled.
- ready  out  1  high in IDLE with no pending request.
- done  out  1  one-cycle pulse after the last frame completes.
- data_latch  out  1  one-cycle pulse to serialiser: start frame with data_in.
- data_in  out  8  staged byte to serialiser.
- data_stop_bit  out  1  stop flag of staged byte.
- busy  in  1  serialiser busy.

## Operation
- Byte sequence, idx 0..18:
  - idx0 = 0x40 (data cmd, auto-increment), stop=1.
  - idx1 = 0xC0 (address 0), stop=0.
  - idx2..17 = grid byte (idx-2); stop=1 only on idx17.
  - idx18 = display_on ? (0x88 | brightness) : 0x80, stop=1.
- On accept, segs/brightness/display_on are snapshotted into shadow registers. Inputs may change freely afterwards.
- start while not IDLE sets a pending flag (one deep; further starts merge). A refresh tick while not IDLE also sets pending.
- States:
  - IDLE: ready=1. On start, pending or refresh tick: snapshot, clear pending, stage idx0, go FIRE.
  - FIRE: data_latch=1 for this cycle. Record in-flight stop flag = staged stop. If that flag is 0, stage next idx (registered, takes effect after this edge, so the serialiser latches the old value). Go ARM.
  - ARM: one wait cycle. Go STREAM.
  - STREAM, waiting for busy==0:
    - In-flight stop=0: the staged byte was consumed. It becomes in-flight; stage the following idx; go ARM.
    - In-flight stop=1 and last byte was idx18: go DONE.
    - In-flight stop=1 otherwise: stage next idx, go GAP.
  - GAP: count GAP_CYCLES, then FIRE.
  - DONE: done=1 for one cycle, go IDLE.
- Refresh counter is free-running when REFRESH_CYCLES>0. It wraps at REFRESH_CYCLES-1 and issues a one-cycle tick.

## Timing
- Reset values: ready=1, done=0, data_latch=0, data_in=0x00, data_stop_bit=0, pending=0, refresh counter=0, state IDLE.
- start in IDLE at cycle N gives data_latch high at cycle N+1 with data_in=0x40, data_stop_bit=1.
- Serialiser continuation timing:
  - A stop=0 byte end shows busy low for exactly 1 cycle.
  - ARM after each handshake skips that dip, so the low cycle is never double-counted.
  - The next staged byte must be stable before the following byte ends; this is met because a byte lasts well over 3 clk cycles.
- data_in/data_stop_bit change only in FIRE, in STREAM on busy-low detection, or in IDLE on accept.
- data_latch is never asserted while busy=1.
- Exactly 3 data_latch pulses and 19 bytes per transaction.
- rst mid-transaction: all state returns to reset values on the next edge. Pending is lost; no done pulse.
- start coincident with DONE → pending set, new transaction begins from IDLE the cycle after.

## Test plan
- Reset, then start with segs=128'h0F0E…0100, brightness=5, display_on=1, with a serialiser model → bytes 0x40 | 0xC0,0x00..0x0F | 0x8D in 3 frames. done pulses once, ready returns to 1.
- display_on=0, brightness=7 → final byte 0x80.
- start held one cycle mid-frame-2 with new segs → transaction completes with old image, then a second full transaction with new image. Exactly one extra transaction for three extra starts.
- REFRESH_CYCLES=2000, no start → transactions begin at fixed 2000-cycle spacing; data_latch never coincides with busy=1.
- Change segs one cycle after accept → transmitted bytes match the snapshot.
- Assert rst during idx9 of frame 2 → outputs at reset values next cycle, no done. A subsequent start produces a full correct 19-byte sequence.
